// File: rtl/i2s_capture_ctrl.sv
// Capture sequencer for the I2S microphone receiver: warm-up discard, counted or
// continuous capture, and a show-ahead sample FIFO drained by the bus wrapper.
module i2s_capture_ctrl #(
  parameter int DATA_W        = 32,
  parameter int SAMPLE_W      = 24,
  parameter int FIFO_DEPTH    = 16,
  parameter int WARMUP_FRAMES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic [CNT_W-1:0]              cfg_num_frames,
  input  logic [$clog2(FIFO_DEPTH):0]   cfg_thresh,
  input  logic                          clr_ovf,
  output logic                          i2s_en,
  input  logic                          i2s_done,
  input  logic [DATA_W-1:0]             i2s_data,
  output logic                          i2s_ack_done,
  output logic                          i2s_ack_data,
  input  logic                          rd_en,
  output logic [SAMPLE_W-1:0]           rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          cap_done,
  output logic                          ovf,
  output logic                          irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP_FRAMES > 0) ? (WARMUP_FRAMES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_done_q;
  logic                r_busy;
  logic                r_en;
  logic                r_ack;
  logic                r_cap_done;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_wcnt;
  logic [CNT_W-1:0]    r_fcnt;
  logic [CNT_W-1:0]    r_num;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;
  logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];

  logic                w_evt;
  logic                w_full;
  logic                w_empty;
  logic                w_start;
  logic                w_cap_evt;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic                w_last;
  logic [CNT_W-1:0]    w_fcnt_nxt;
  logic                w_unused_lsbs;

  assign w_evt      = i2s_done & ~r_done_q;
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  // stop beats start when both arrive in IDLE
  assign w_start    = start & ~stop & (r_state == ST_IDLE);
  assign w_cap_evt  = w_evt & ~stop & (r_state == ST_CAPTURE);
  assign w_push     = w_cap_evt & (~w_full | rd_en);
  assign w_drop     = w_cap_evt & w_full & ~rd_en;
  assign w_pop      = rd_en & ~w_empty & ~w_start;
  assign w_fcnt_nxt = r_fcnt + CNT_W'(1);
  assign w_last     = (r_num != '0) && (w_fcnt_nxt == r_num);
  assign w_unused_lsbs = ^i2s_data[DATA_W-SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_done_q   <= 1'b0;
      r_busy     <= 1'b0;
      r_en       <= 1'b0;
      r_ack      <= 1'b0;
      r_cap_done <= 1'b0;
      r_wcnt     <= '0;
      r_fcnt     <= '0;
      r_num      <= '0;
    end else begin
      r_done_q   <= i2s_done;
      r_ack      <= w_evt & (r_state != ST_IDLE);
      r_cap_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_num  <= cfg_num_frames;
            r_wcnt <= '0;
            r_fcnt <= '0;
            r_busy <= 1'b1;
            r_en   <= 1'b1;
            r_state <= (WARMUP_FRAMES == 0) ? ST_CAPTURE : ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_en    <= 1'b0;
          end else if (w_evt) begin
            if (r_wcnt == WARM_LAST) begin
              r_state <= ST_CAPTURE;
            end else begin
              r_wcnt <= r_wcnt + CNT_W'(1);
            end
          end
        end
        ST_CAPTURE: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_en    <= 1'b0;
          end else if (w_evt) begin
            r_fcnt <= w_fcnt_nxt;
            if (w_last) begin
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
              r_en       <= 1'b0;
              r_cap_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i2s_data[DATA_W-1 -: SAMPLE_W];
  end

  // a drop in the same cycle as clr_ovf keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign i2s_en       = r_en;
  assign i2s_ack_done = r_ack;
  assign i2s_ack_data = 1'b0;
  assign rd_data      = r_mem[r_rptr];
  assign fifo_empty   = w_empty;
  assign fifo_full    = w_full;
  assign fifo_count   = r_count;
  assign busy         = r_busy;
  assign cap_done     = r_cap_done;
  assign ovf          = r_ovf;
  assign irq          = ((cfg_thresh != '0) && (r_count >= cfg_thresh)) || r_ovf;

endmodule
